// File: rtl/marker_pkg.sv
// Shared types and decode helper for the phase-marker event queue.
// Markers are `slti x0,x0,ID`; the immediate field carries the phase ID.
package marker_pkg;

  localparam logic [19:0] MARKER_LOW20  = 20'h02013;
  localparam logic [11:0] MARKER_MAX_ID = 12'd13;
  localparam int          DEFAULT_TS_W  = 64;

  // Phase p owns marker IDs 2p (START) and 2p+1 (END).
  typedef enum logic [2:0] {
    PH_VCTM, PH_DELAY, PH_TEXE, PH_LEAK, PH_INIT, PH_BIM, PH_TRAIN
  } phase_e;

  typedef enum logic {
    PHASE_IDLE,
    PHASE_OPEN
  } phase_state_e;

  typedef struct packed {
    logic [3:0]              id;
    logic                    commit;
    logic [DEFAULT_TS_W-1:0] stamp;
  } marker_evt_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] id;
  } marker_dec_t;

  function automatic marker_dec_t decode_marker(input logic [31:0] inst);
    marker_dec_t dec;
    dec.hit = (inst[19:0] == MARKER_LOW20) && (inst[31:20] <= MARKER_MAX_ID);
    dec.id  = inst[23:20];
    return dec;
  endfunction

endpackage

// File: rtl/marker_event_queue_if.sv
// ROB-side marker streams plus the event-logger drain and status signals.
// master = ROB/logger side, slave = marker_event_queue.
interface marker_event_queue_if #(
    parameter int TS_W       = 64,
    parameter int NUM_PHASES = 7,
    parameter int DROP_W     = 16
);
    logic                  enq_valid;
    logic [31:0]           enq_inst;
    logic                  commit_valid;
    logic [31:0]           commit_inst;
    logic                  evt_valid;
    logic                  evt_ready;
    logic [3:0]            evt_id;
    logic                  evt_commit;
    logic [TS_W-1:0]       evt_time;
    logic [DROP_W-1:0]     drop_count;
    logic [NUM_PHASES-1:0] open_phases;
    logic                  proto_err;

    modport master (
        output enq_valid, enq_inst, commit_valid, commit_inst, evt_ready,
        input  evt_valid, evt_id, evt_commit, evt_time, drop_count, open_phases, proto_err
    );

    modport slave (
        input  enq_valid, enq_inst, commit_valid, commit_inst, evt_ready,
        output evt_valid, evt_id, evt_commit, evt_time, drop_count, open_phases, proto_err
    );
endinterface

// File: rtl/marker_fifo2w.sv
// Dual-write, single-read event FIFO; port 0 has write priority over port 1.
// A pop in the same cycle frees a slot for that cycle's writes; overflow is counted.
module marker_fifo2w
    import marker_pkg::*;
#(
    parameter int  DEPTH  = 16,
    parameter int  DROP_W = 16,
    parameter type evt_t  = marker_evt_t
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr0_valid,
    input  evt_t              wr0_data,
    input  logic              wr1_valid,
    input  evt_t              wr1_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output evt_t              rd_data,
    output logic [DROP_W-1:0] drop_count
);
    localparam int AW = $clog2(DEPTH);

    evt_t              mem [DEPTH];
    evt_t              last_q;
    logic [AW:0]       wr_ptr, rd_ptr, count, wr1_ptr;
    logic [AW+1:0]     free;
    logic              pop, acc0, acc1;
    logic [1:0]        n_drop;
    logic [DROP_W:0]   drop_sum;
    logic [DROP_W-1:0] drop_q;

    assign count    = wr_ptr - rd_ptr;
    assign rd_valid = (count != '0);
    assign pop      = rd_valid & rd_ready;
    assign free     = (AW+2)'(DEPTH) - {1'b0, count} + (AW+2)'(pop);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (wr0_valid && wr1_valid) begin
            acc0 = (free >= (AW+2)'(1));
            acc1 = (free >= (AW+2)'(2));
        end else if (wr0_valid) begin
            acc0 = (free >= (AW+2)'(1));
        end else if (wr1_valid) begin
            acc1 = (free >= (AW+2)'(1));
        end
        n_drop   = {1'b0, wr0_valid & ~acc0} + {1'b0, wr1_valid & ~acc1};
        wr1_ptr  = wr_ptr + (AW+1)'(acc0);
        drop_sum = {1'b0, drop_q} + (DROP_W+1)'(n_drop);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop_q <= '0;
            last_q <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(acc0) + (AW+1)'(acc1);
            rd_ptr <= rd_ptr + (AW+1)'(pop);
            drop_q <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            if (pop) last_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (acc0) mem[wr_ptr[AW-1:0]]  <= wr0_data;
        if (acc1) mem[wr1_ptr[AW-1:0]] <= wr1_data;
    end

    // When empty the outputs keep showing the most recently consumed event.
    assign rd_data    = rd_valid ? mem[rd_ptr[AW-1:0]] : last_q;
    assign drop_count = drop_q;

endmodule

// File: rtl/marker_event_queue.sv
// Decodes phase markers on the ROB enqueue/commit streams, timestamps and queues them,
// and tracks per-phase open/closed state on the commit stream.
module marker_event_queue
    import marker_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int TS_W       = 64,
    parameter int NUM_PHASES = 7,
    parameter int DROP_W     = 16
) (
    input logic                 clock,
    input logic                 reset,
    marker_event_queue_if.slave bus
);
    typedef struct packed {
        logic [3:0]      id;
        logic            commit;
        logic [TS_W-1:0] stamp;
    } evt_t;

    logic [TS_W-1:0]       cycle_q;
    marker_dec_t           enq_dec, com_dec;
    logic                  enq_hit, com_hit, head_valid;
    evt_t                  enq_evt, com_evt, head_evt;
    logic [NUM_PHASES-1:0] open_vec, phase_err;
    logic                  proto_err_q;

    always_ff @(posedge clock) begin
        if (!reset) cycle_q <= '0;
        else        cycle_q <= cycle_q + TS_W'(1);
    end

    always_comb begin
        enq_dec = decode_marker(bus.enq_inst);
        com_dec = decode_marker(bus.commit_inst);
    end

    assign enq_hit = bus.enq_valid & enq_dec.hit;
    assign com_hit = bus.commit_valid & com_dec.hit;
    assign enq_evt = '{id: enq_dec.id, commit: 1'b0, stamp: cycle_q};
    assign com_evt = '{id: com_dec.id, commit: 1'b1, stamp: cycle_q};

    marker_fifo2w #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W),
        .evt_t  (evt_t)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .wr0_valid  (enq_hit),
        .wr0_data   (enq_evt),
        .wr1_valid  (com_hit),
        .wr1_data   (com_evt),
        .rd_valid   (head_valid),
        .rd_ready   (bus.evt_ready),
        .rd_data    (head_evt),
        .drop_count (bus.drop_count)
    );

    // One IDLE/OPEN tracker per phase; only commit-stream markers move it, dropped or not.
    for (genvar p = 0; p < NUM_PHASES; p++) begin : g_phase
        phase_state_e state_q, state_d;
        logic         sel, is_start, is_open, bad;

        assign sel      = com_hit && (com_dec.id[3:1] == 3'(p));
        assign is_start = ~com_dec.id[0];

        always_ff @(posedge clock) begin
            if (!reset) state_q <= PHASE_IDLE;
            else        state_q <= state_d;
        end

        always_comb begin
            state_d = state_q;
            if (sel) begin
                unique case (state_q)
                    PHASE_IDLE: if (is_start)  state_d = PHASE_OPEN;
                    PHASE_OPEN: if (!is_start) state_d = PHASE_IDLE;
                endcase
            end
        end

        always_comb begin
            is_open = (state_q == PHASE_OPEN);
            bad     = sel && (is_start == is_open);
        end

        assign open_vec[p]  = is_open;
        assign phase_err[p] = bad;
    end

    always_ff @(posedge clock) begin
        if (!reset)          proto_err_q <= 1'b0;
        else if (|phase_err) proto_err_q <= 1'b1;
    end

    assign bus.evt_valid   = head_valid;
    assign bus.evt_id      = head_evt.id;
    assign bus.evt_commit  = head_evt.commit;
    assign bus.evt_time    = head_evt.stamp;
    assign bus.open_phases = open_vec;
    assign bus.proto_err   = proto_err_q;

endmodule

// File: tb/tb_marker_event_queue.sv
// Self-checking bench for marker_event_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model updated once per clock.
module tb_marker_event_queue;
    localparam int DEPTH      = 16;
    localparam int TS_W       = 64;
    localparam int NUM_PHASES = 7;
    localparam int DROP_W     = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    marker_event_queue_if #(.TS_W(TS_W), .NUM_PHASES(NUM_PHASES), .DROP_W(DROP_W)) bus ();

    marker_event_queue #(
        .DEPTH(DEPTH), .TS_W(TS_W), .NUM_PHASES(NUM_PHASES), .DROP_W(DROP_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]      id;
        logic            commit;
        logic [TS_W-1:0] t;
    } mev_t;

    mev_t                  mq[$];
    mev_t                  mlast;
    logic [TS_W-1:0]       mcnt;
    logic [DROP_W-1:0]     mdrop;
    logic [NUM_PHASES-1:0] mopen;
    logic                  merr;
    int                    n_checks = 0;
    int                    n_fail   = 0;

    function automatic bit is_marker(input logic [31:0] inst, output logic [3:0] id);
        id = inst[23:20];
        return (inst[19:0] == 20'h02013) && (inst[31:20] <= 12'd13);
    endfunction

    function automatic logic [31:0] rand_inst();
        int unsigned r;
        logic [11:0] imm;
        r = $urandom_range(0, 9);
        if (r < 7) begin
            imm = 12'($urandom_range(0, 13));
            return {imm, 20'h02013};
        end
        if (r == 7) begin
            imm = 12'($urandom_range(14, 4095));
            return {imm, 20'h02013};
        end
        return $urandom();
    endfunction

    task automatic drive(input logic ev, input logic [31:0] ei,
                         input logic cv, input logic [31:0] ci, input logic rdy);
        bus.enq_valid    = ev;
        bus.enq_inst     = ei;
        bus.commit_valid = cv;
        bus.commit_inst  = ci;
        bus.evt_ready    = rdy;
    endtask

    // Advance the reference model over the coming edge, then step the clock.
    task automatic tick();
        logic [3:0] eid, cid;
        bit         eh, ch;
        int         free, p;
        eh = is_marker(bus.enq_inst, eid) && bus.enq_valid;
        ch = is_marker(bus.commit_inst, cid) && bus.commit_valid;
        if (reset == 1'b0) begin
            mq.delete();
            mlast = '{4'd0, 1'b0, '0};
            mcnt  = '0;
            mdrop = '0;
            mopen = '0;
            merr  = 1'b0;
        end else begin
            free = DEPTH - mq.size();
            if (mq.size() > 0 && bus.evt_ready) begin
                mlast = mq.pop_front();
                free++;
            end
            if (eh) begin
                if (free > 0) begin mq.push_back('{eid, 1'b0, mcnt}); free--; end
                else if (mdrop != '1) mdrop++;
            end
            if (ch) begin
                if (free > 0) begin mq.push_back('{cid, 1'b1, mcnt}); free--; end
                else if (mdrop != '1) mdrop++;
                p = int'(cid) / 2;
                if (cid[0] == 1'b0) begin
                    if (mopen[p]) merr = 1'b1;
                    mopen[p] = 1'b1;
                end else begin
                    if (!mopen[p]) merr = 1'b1;
                    mopen[p] = 1'b0;
                end
            end
            mcnt++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 32'h0, 0, 32'h0, 0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.evt_valid, bus.evt_id, bus.evt_commit} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_head: got valid=%0b id=%0d commit=%0b want 0/0/0",
                     bus.evt_valid, bus.evt_id, bus.evt_commit);
        end
        n_checks++;
        if (bus.evt_time !== '0) begin
            n_fail++; $display("FAIL reset_time: got %0d want 0", bus.evt_time);
        end
        n_checks++;
        if ({bus.drop_count, bus.open_phases, bus.proto_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_status: got drop=%0d open=%0h err=%0b want 0/0/0",
                     bus.drop_count, bus.open_phases, bus.proto_err);
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        drive(1, 32'h00402013, 0, 32'h0, 1);
        tick();
        n_checks++;
        if ({bus.evt_valid, bus.evt_id, bus.evt_commit} !== {1'b1, 4'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL single_head: got valid=%0b id=%0d commit=%0b want 1/4/0",
                     bus.evt_valid, bus.evt_id, bus.evt_commit);
        end
        n_checks++;
        if (bus.evt_time !== 64'd5) begin
            n_fail++; $display("FAIL single_time: got %0d want 5", bus.evt_time);
        end
        drive(0, 32'h0, 0, 32'h0, 1);
        tick();
        n_checks++;
        if (bus.evt_valid !== 1'b0 || bus.evt_id !== 4'd4) begin
            n_fail++;
            $display("FAIL single_drained: got valid=%0b id=%0d want 0/4 (held)",
                     bus.evt_valid, bus.evt_id);
        end
    endtask

    task automatic test_dual();
        do_reset();
        drive(1, 32'h00002013, 1, 32'h00102013, 0);
        tick();
        drive(0, 32'h0, 0, 32'h0, 0);
        n_checks++;
        if ({bus.evt_valid, bus.evt_id, bus.evt_commit} !== {1'b1, 4'd0, 1'b0} || bus.evt_time !== 64'd0) begin
            n_fail++;
            $display("FAIL dual_first: got valid=%0b id=%0d commit=%0b time=%0d want 1/0/0/0",
                     bus.evt_valid, bus.evt_id, bus.evt_commit, bus.evt_time);
        end
        tick();
        n_checks++;
        if ({bus.evt_valid, bus.evt_id, bus.evt_commit} !== {1'b1, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL dual_stall: got valid=%0b id=%0d commit=%0b want 1/0/0",
                     bus.evt_valid, bus.evt_id, bus.evt_commit);
        end
        bus.evt_ready = 1'b1;
        tick();
        n_checks++;
        if ({bus.evt_valid, bus.evt_id, bus.evt_commit} !== {1'b1, 4'd1, 1'b1} || bus.evt_time !== 64'd0) begin
            n_fail++;
            $display("FAIL dual_second: got valid=%0b id=%0d commit=%0b time=%0d want 1/1/1/0",
                     bus.evt_valid, bus.evt_id, bus.evt_commit, bus.evt_time);
        end
        n_checks++;
        if (bus.proto_err !== 1'b1) begin
            n_fail++; $display("FAIL dual_end_in_idle: got err=%0b want 1", bus.proto_err);
        end
    endtask

    task automatic test_full_drop();
        logic [11:0] imm;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            imm = 12'(i % 14);
            drive(1, {imm, 20'h02013}, 0, 32'h0, 0);
            tick();
        end
        n_checks++;
        if (bus.drop_count !== 16'd1 || bus.evt_id !== 4'd0 || bus.evt_time !== 64'd0) begin
            n_fail++;
            $display("FAIL full_drop: got drop=%0d id=%0d time=%0d want 1/0/0",
                     bus.drop_count, bus.evt_id, bus.evt_time);
        end
        drive(0, 32'h0, 0, 32'h0, 1);
        tick();
        drive(1, 32'h00402013, 1, 32'h00c02013, 1);
        tick();
        n_checks++;
        if (bus.drop_count !== 16'd1) begin
            n_fail++; $display("FAIL pop_frees_two: got drop=%0d want 1", bus.drop_count);
        end
        drive(1, 32'h00402013, 1, 32'h00c02013, 0);
        tick();
        n_checks++;
        if (bus.drop_count !== 16'd3) begin
            n_fail++; $display("FAIL zero_free_pair: got drop=%0d want 3", bus.drop_count);
        end
        drive(1, 32'h00402013, 1, 32'h00c02013, 1);
        tick();
        n_checks++;
        if (bus.drop_count !== 16'd4) begin
            n_fail++; $display("FAIL one_free_pair: got drop=%0d want 4", bus.drop_count);
        end
        drive(0, 32'h0, 0, 32'h0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (mq.size() == 0 || bus.evt_valid !== 1'b1 || bus.evt_id !== mq[0].id ||
                bus.evt_commit !== mq[0].commit || bus.evt_time !== mq[0].t) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got valid=%0b id=%0d commit=%0b time=%0d model_size=%0d",
                         i, bus.evt_valid, bus.evt_id, bus.evt_commit, bus.evt_time, mq.size());
            end
            tick();
        end
        n_checks++;
        if (bus.evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty: got valid=%0b want 0", bus.evt_valid);
        end
    endtask

    task automatic test_phase();
        do_reset();
        drive(0, 32'h0, 1, 32'h00c02013, 1);
        tick();
        n_checks++;
        if (bus.open_phases !== 7'h40 || bus.proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL phase_open: got open=%0h err=%0b want 40/0", bus.open_phases, bus.proto_err);
        end
        drive(0, 32'h0, 1, 32'h00d02013, 1);
        tick();
        n_checks++;
        if (bus.open_phases !== 7'h00 || bus.proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL phase_close: got open=%0h err=%0b want 0/0", bus.open_phases, bus.proto_err);
        end
        drive(0, 32'h0, 1, 32'h00302013, 1);
        tick();
        n_checks++;
        if (bus.proto_err !== 1'b1) begin
            n_fail++; $display("FAIL phase_end_idle: got err=%0b want 1", bus.proto_err);
        end
        drive(0, 32'h0, 1, 32'h00402013, 1);
        tick();
        drive(0, 32'h0, 1, 32'h00502013, 1);
        tick();
        n_checks++;
        if (bus.proto_err !== 1'b1 || bus.open_phases !== 7'h00) begin
            n_fail++;
            $display("FAIL phase_sticky: got open=%0h err=%0b want 0/1", bus.open_phases, bus.proto_err);
        end
    endtask

    task automatic test_nonmarker();
        do_reset();
        drive(1, 32'h00e02013, 1, 32'h00002033, 0);
        tick();
        drive(0, 32'h00402013, 0, 32'h00102013, 0);
        tick();
        n_checks++;
        if (bus.evt_valid !== 1'b0 || bus.drop_count !== '0 ||
            bus.open_phases !== '0 || bus.proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL nonmarker: got valid=%0b drop=%0d open=%0h err=%0b want 0/0/0/0",
                     bus.evt_valid, bus.drop_count, bus.open_phases, bus.proto_err);
        end
    endtask

    task automatic test_random();
        mev_t h;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            drive(1'($urandom_range(0, 1)), rand_inst(), 1'($urandom_range(0, 1)), rand_inst(),
                  ($urandom_range(0, 9) < 4));
            tick();
            h = (mq.size() > 0) ? mq[0] : mlast;
            n_checks++;
            if (bus.evt_valid !== (mq.size() > 0) || bus.evt_id !== h.id ||
                bus.evt_commit !== h.commit || bus.evt_time !== h.t) begin
                n_fail++;
                $display("FAIL rand_head[%0d]: got valid=%0b id=%0d commit=%0b time=%0d want %0b/%0d/%0b/%0d",
                         cyc, bus.evt_valid, bus.evt_id, bus.evt_commit, bus.evt_time,
                         mq.size() > 0, h.id, h.commit, h.t);
            end
            n_checks++;
            if (bus.drop_count !== mdrop || bus.open_phases !== mopen || bus.proto_err !== merr) begin
                n_fail++;
                $display("FAIL rand_status[%0d]: got drop=%0d open=%0h err=%0b want %0d/%0h/%0b",
                         cyc, bus.drop_count, bus.open_phases, bus.proto_err, mdrop, mopen, merr);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 32'h00002013, 1, 32'h00402013, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h00802013, 0, 32'h0, 0);
            tick();
        end
        n_checks++;
        if (bus.open_phases !== 7'h04 || bus.evt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: got open=%0h valid=%0b want 04/1", bus.open_phases, bus.evt_valid);
        end
        reset = 1'b0;
        drive(0, 32'h0, 0, 32'h0, 0);
        tick();
        n_checks++;
        if (bus.evt_valid !== 1'b0 || bus.open_phases !== '0 || bus.evt_time !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%0b open=%0h time=%0d want 0/0/0",
                     bus.evt_valid, bus.open_phases, bus.evt_time);
        end
        reset = 1'b1;
        drive(1, 32'h00602013, 0, 32'h0, 0);
        tick();
        n_checks++;
        if (bus.evt_valid !== 1'b1 || bus.evt_id !== 4'd6 || bus.evt_time !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_restart: got valid=%0b id=%0d time=%0d want 1/6/0",
                     bus.evt_valid, bus.evt_id, bus.evt_time);
        end
    endtask

    initial begin
        drive(0, 32'h0, 0, 32'h0, 0);
        test_reset();
        test_single();
        test_dual();
        test_full_drop();
        test_phase();
        test_nonmarker();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
